// File: rtl/clk_div_pkg.sv
// Shared types and constants for the divided-clock monitor.
// State encoding is fixed so debug probes can decode it directly.

package clk_div_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSync    = 2'd1,
        StMeasure = 2'd2,
        StLocked  = 2'd3
    } state_e;

    localparam int unsigned ErrCntW = 8;

    // Holds the consecutive-good-period count; LOCK_CNT is limited to 1..15.
    localparam int unsigned GoodW = 4;

    function automatic logic [ErrCntW-1:0] err_cnt_inc(input logic [ErrCntW-1:0] cnt);
        logic [ErrCntW-1:0] max_cnt;
        max_cnt = '1;
        return (cnt == max_cnt) ? cnt : cnt + ErrCntW'(1);
    endfunction

endpackage

// File: rtl/clk_div_edge_cnt.sv
// Rising-edge detector plus period and high-time counters for the sampled divided clock.
// Both counters restart at 1 on a rise and saturate at all-ones.

module clk_div_edge_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             div_in,
    output logic             rise,
    output logic [CNT_W-1:0] pcnt,
    output logic [CNT_W-1:0] hcnt,
    output logic             pcnt_sat
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic             div_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;

    assign rise     = div_in & ~div_d;
    assign pcnt_sat = (pcnt_q == CntMax);
    assign pcnt     = pcnt_q;
    assign hcnt     = hcnt_q;

    always_comb begin
        pcnt_d = pcnt_q;
        hcnt_d = hcnt_q;
        if (clr) begin
            pcnt_d = '0;
            hcnt_d = '0;
        end else if (rise) begin
            pcnt_d = CNT_W'(1);
            hcnt_d = CNT_W'(1);
        end else begin
            if (!pcnt_sat) begin
                pcnt_d = pcnt_q + CNT_W'(1);
            end
            // High time never exceeds the period in a measured window; saturation only
            // matters while waiting in SYNC with the input stuck high.
            if (div_in && (hcnt_q != CntMax)) begin
                hcnt_d = hcnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_d  <= 1'b0;
            pcnt_q <= '0;
            hcnt_q <= '0;
        end else begin
            div_d  <= div_in;
            pcnt_q <= pcnt_d;
            hcnt_q <= hcnt_d;
        end
    end

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period/high time of a divided clock and reports lock and mismatch status.
// Define CLK_DIV_MON_ERRCNT_EN to build the saturating error counter; otherwise err_count is 0.

module clk_div_monitor
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               div_in,
    input  logic [CNT_W-1:0]   exp_period,
    input  logic [CNT_W-1:0]   exp_high,
    output logic [CNT_W-1:0]   period_meas,
    output logic [CNT_W-1:0]   high_meas,
    output logic               meas_valid,
    output logic               lock,
    output logic               err_period,
    output logic               err_duty,
    output logic [ErrCntW-1:0] err_count
);

    state_e             state_q, state_d;
    logic [GoodW-1:0]   good_q, good_d;
    logic [CNT_W-1:0]   exp_period_q, exp_period_d;
    logic [CNT_W-1:0]   exp_high_q, exp_high_d;
    logic [CNT_W-1:0]   period_meas_q, period_meas_d;
    logic [CNT_W-1:0]   high_meas_q, high_meas_d;
    logic               meas_valid_q, meas_valid_d;
    logic               err_period_q, err_period_d;
    logic               err_duty_q, err_duty_d;
    logic               lock_q;

    logic               rise;
    logic               pcnt_sat;
    logic [CNT_W-1:0]   pcnt;
    logic [CNT_W-1:0]   hcnt;
    logic               cnt_clr;
    logic               period_bad;
    logic               duty_bad;

    // Counters idle at zero whenever the monitor is or is about to be in IDLE.
    assign cnt_clr = !en || (state_q == StIdle);

    clk_div_edge_cnt #(
        .CNT_W (CNT_W)
    ) u_edge_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .div_in   (div_in),
        .rise     (rise),
        .pcnt     (pcnt),
        .hcnt     (hcnt),
        .pcnt_sat (pcnt_sat)
    );

    assign period_bad = (pcnt != exp_period_q);
    assign duty_bad   = (hcnt != exp_high_q);

    always_comb begin
        state_d       = state_q;
        good_d        = good_q;
        exp_period_d  = exp_period_q;
        exp_high_d    = exp_high_q;
        period_meas_d = period_meas_q;
        high_meas_d   = high_meas_q;
        meas_valid_d  = 1'b0;
        err_period_d  = 1'b0;
        err_duty_d    = 1'b0;

        if (!en) begin
            state_d = StIdle;
            good_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    exp_period_d = exp_period;
                    exp_high_d   = exp_high;
                    state_d      = StSync;
                end
                StSync: begin
                    // First rise only aligns us; the partial period before it is discarded.
                    if (rise) begin
                        state_d = StMeasure;
                    end
                end
                StMeasure, StLocked: begin
                    if (rise) begin
                        period_meas_d = pcnt;
                        high_meas_d   = hcnt;
                        meas_valid_d  = 1'b1;
                        if (period_bad || duty_bad) begin
                            err_period_d = period_bad;
                            err_duty_d   = duty_bad;
                            good_d       = '0;
                            state_d      = StMeasure;
                        end else if (state_q == StMeasure) begin
                            good_d = good_q + GoodW'(1);
                            if (good_d == GoodW'(LOCK_CNT)) begin
                                state_d = StLocked;
                            end
                        end
                    end else if (pcnt_sat) begin
                        // Divider stopped toggling: report and re-align from scratch.
                        err_period_d = 1'b1;
                        good_d       = '0;
                        state_d      = StSync;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            good_q        <= '0;
            exp_period_q  <= '0;
            exp_high_q    <= '0;
            period_meas_q <= '0;
            high_meas_q   <= '0;
            meas_valid_q  <= 1'b0;
            err_period_q  <= 1'b0;
            err_duty_q    <= 1'b0;
            lock_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            good_q        <= good_d;
            exp_period_q  <= exp_period_d;
            exp_high_q    <= exp_high_d;
            period_meas_q <= period_meas_d;
            high_meas_q   <= high_meas_d;
            meas_valid_q  <= meas_valid_d;
            err_period_q  <= err_period_d;
            err_duty_q    <= err_duty_d;
            lock_q        <= (state_d == StLocked);
        end
    end

    assign period_meas = period_meas_q;
    assign high_meas   = high_meas_q;
    assign meas_valid  = meas_valid_q;
    assign err_period  = err_period_q;
    assign err_duty    = err_duty_q;
    assign lock        = lock_q;

`ifdef CLK_DIV_MON_ERRCNT_EN
    logic [ErrCntW-1:0] err_count_q;

    // Counts error cycles, so a simultaneous period+duty mismatch adds only one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else if (err_period_q || err_duty_q) begin
            err_count_q <= err_cnt_inc(err_count_q);
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = '0;
`endif

    a_err_drops_lock : assert property (@(posedge clk) disable iff (!rst_n)
        (err_period || err_duty) |-> !lock);

    a_meas_pulse : assert property (@(posedge clk) disable iff (!rst_n)
        meas_valid |=> !meas_valid);

endmodule
